// File: rtl/fp_mul_seq.sv
// ----------------------------------------------------------------------------
// fp_mul_seq
//   Issue/completion sequencer between the ALU execute stage and a multi-cycle
//   FP32 multiply core. Special operands and out-of-range exponents are
//   answered locally in one cycle. Normal operands are handed to the core.
//   The core's exponent is re-biased before the tagged result is held for
//   writeback.
//
// Ports
//   i_clk, i_rst_n        clock, synchronous active-low reset
//   i_valid / o_ready     request handshake from execute stage
//   i_a, i_b, i_tag       FP32 operands and destination tag
//   o_valid / i_ready     result handshake to writeback
//   o_result, o_tag       FP32 product and its tag
//   o_err                 core timed out (qualified by o_valid)
//   o_mul_valid           one-cycle start pulse to the core
//   o_mul_a, o_mul_b      operands to the core, stable until the next accept
//   i_mul_valid           core done level (stays high until the next start)
//   i_mul_result          core product, exponent not yet re-biased
// ----------------------------------------------------------------------------
module fp_mul_seq #(
    parameter int unsigned TIMEOUT = 31,
    parameter int unsigned TAG_W   = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [31:0]      i_a,
    input  logic [31:0]      i_b,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_err,
    output logic             o_mul_valid,
    output logic [31:0]      o_mul_a,
    output logic [31:0]      o_mul_b,
    input  logic             i_mul_valid,
    input  logic [31:0]      i_mul_result
);

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [4:0]  TO_LAST = 5'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e             state_q;
    logic               valid_q;
    logic               mul_valid_q;
    logic               err_q;
    logic [31:0]        result_q;
    logic [TAG_W-1:0]   tag_q;
    logic [31:0]        mul_a_q;
    logic [31:0]        mul_b_q;
    logic               seen_low_q;
    logic [4:0]         cnt_q;
    logic               sign_q;
    logic signed [9:0]  exp_q;     // predicted biased exponent a_exp + b_exp - 127
    logic [7:0]         sum_q;     // (a_exp + b_exp) mod 256, as the core reports it

    // Operand screening, evaluated on the live request.
    logic [7:0]         a_exp, b_exp;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               sign_d;
    logic signed [9:0]  exp_d;
    logic               fast_d;
    logic [31:0]        fast_res_d;

    // Completion path, evaluated on the core's result.
    logic [7:0]         carry_d;
    logic signed [9:0]  fin_exp_d;
    logic [31:0]        slow_res_d;

    // The core's sign bit is redundant with sign_q.
    logic               unused_core_sign;
    assign unused_core_sign = i_mul_result[31];

    assign a_exp  = i_a[30:23];
    assign b_exp  = i_b[30:23];
    assign a_nan  = (a_exp == 8'hFF) && (i_a[22:0] != 23'd0);
    assign b_nan  = (b_exp == 8'hFF) && (i_b[22:0] != 23'd0);
    assign a_inf  = (a_exp == 8'hFF) && (i_a[22:0] == 23'd0);
    assign b_inf  = (b_exp == 8'hFF) && (i_b[22:0] == 23'd0);
    assign a_zero = (a_exp == 8'h00);   // denormals are flushed to zero
    assign b_zero = (b_exp == 8'h00);
    assign sign_d = i_a[31] ^ i_b[31];
    assign exp_d  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - 10'sd127;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fast_d     = 1'b1;
        fast_res_d = QNAN;
        if (a_nan || b_nan) begin
            fast_res_d = QNAN;
        end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
            fast_res_d = QNAN;
        end else if (a_inf || b_inf) begin
            fast_res_d = {sign_d, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            fast_res_d = {sign_d, 31'd0};
        end else if (exp_d >= 10'sd255) begin
            fast_res_d = {sign_d, 8'hFF, 23'd0};
        end else if (exp_d <= 10'sd0) begin
            fast_res_d = {sign_d, 31'd0};
        end else begin
            fast_d = 1'b0;
        end
    end

    // The core reports a_exp + b_exp (+1 if its mantissa normalised up) in
    // 8 bits; the difference to the latched sum recovers that carry.
    assign carry_d    = i_mul_result[30:23] - sum_q;
    assign fin_exp_d  = exp_q + $signed({2'b00, carry_d});
    assign slow_res_d = (fin_exp_d == 10'sd255) ? {sign_q, 8'hFF, 23'd0}
                                                : {sign_q, fin_exp_d[7:0], i_mul_result[22:0]};

    // NOTE: the reset branch covers every register, so a reset mid-operation
    // leaves nothing behind that could surface as a stale result.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            mul_valid_q <= 1'b0;
            err_q       <= 1'b0;
            result_q    <= 32'd0;
            tag_q       <= '0;
            mul_a_q     <= 32'd0;
            mul_b_q     <= 32'd0;
            seen_low_q  <= 1'b0;
            cnt_q       <= 5'd0;
            sign_q      <= 1'b0;
            exp_q       <= 10'sd0;
            sum_q       <= 8'd0;
        end else begin
            // NOTE: non-blocking assignments throughout; this default makes the start a single-cycle pulse.
            mul_valid_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (i_valid) begin
                        tag_q   <= i_tag;
                        mul_a_q <= i_a;
                        mul_b_q <= i_b;
                        sign_q  <= sign_d;
                        exp_q   <= exp_d;
                        sum_q   <= a_exp + b_exp;
                        err_q   <= 1'b0;
                        if (fast_d) begin
                            result_q <= fast_res_d;
                            valid_q  <= 1'b1;
                            state_q  <= ST_RESP;
                        end else begin
                            mul_valid_q <= 1'b1;
                            seen_low_q  <= 1'b0;
                            cnt_q       <= 5'd0;
                            state_q     <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A level still high from the previous operation must
                    // drop once before it can count as completion.
                    if (!i_mul_valid) begin
                        seen_low_q <= 1'b1;
                    end
                    if (i_mul_valid && seen_low_q) begin
                        result_q <= slow_res_d;
                        valid_q  <= 1'b1;
                        state_q  <= ST_RESP;
                    end else if (cnt_q == TO_LAST) begin
                        result_q <= QNAN;
                        err_q    <= 1'b1;
                        valid_q  <= 1'b1;
                        state_q  <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 5'd1;
                    end
                end
                ST_RESP: begin
                    if (i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_ready     = (state_q == ST_IDLE);
    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_tag       = tag_q;
    assign o_err       = err_q;
    assign o_mul_valid = mul_valid_q;
    assign o_mul_a     = mul_a_q;
    assign o_mul_b     = mul_b_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// ----------------------------------------------------------------------------
// tb_fp_mul_seq
//   Directed and randomized stimulus for fp_mul_seq with a multi-cycle core
//   stub. Expected products come from an FP32 reference model written with
//   plain integer arithmetic on the operand fields.
// ----------------------------------------------------------------------------
module tb_fp_mul_seq;

    localparam int TAG_W = 5;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_a;
    logic [31:0]      i_b;
    logic [TAG_W-1:0] i_tag;
    logic             o_valid;
    logic             i_ready;
    logic [31:0]      o_result;
    logic [TAG_W-1:0] o_tag;
    logic             o_err;
    logic             o_mul_valid;
    logic [31:0]      o_mul_a;
    logic [31:0]      o_mul_b;
    logic             i_mul_valid;
    logic [31:0]      i_mul_result;

    fp_mul_seq #(.TIMEOUT(31), .TAG_W(TAG_W)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_a          (i_a),
        .i_b          (i_b),
        .i_tag        (i_tag),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_tag        (o_tag),
        .o_err        (o_err),
        .o_mul_valid  (o_mul_valid),
        .o_mul_a      (o_mul_a),
        .o_mul_b      (o_mul_b),
        .i_mul_valid  (i_mul_valid),
        .i_mul_result (i_mul_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int vectors     = 0;
    int miscompares = 0;
    int pulse_cnt   = 0;

    // Core stub controls: 0 = normal, 1 = stale high for 3 cycles, 2 = never completes.
    int          core_mode = 0;
    int          core_lat  = 1;
    bit          core_fc   = 1'b0;   // force the core to report a normalisation carry
    int          stub_c    = -1;
    logic [31:0] stub_res;

    // Behaviour of the multiply core: full mantissa product, truncated,
    // exponent reported as a_exp + b_exp + carry (mod 256) with no bias removed.
    function automatic logic [31:0] core_model(input logic [31:0] a, input logic [31:0] b, input bit fc);
        logic [47:0] p;
        logic        c;
        logic [22:0] f;
        logic [7:0]  e;
        p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        c = p[47];
        f = c ? p[46:24] : p[45:23];
        if (fc) c = 1'b1;
        e = a[30:23] + b[30:23] + {7'd0, c};
        return {a[31] ^ b[31], e, f};
    endfunction

    // End-to-end FP32 product as the sequencer must deliver it.
    function automatic void ref_model(input logic [31:0] a, input logic [31:0] b, input bit fc,
                                      output logic [31:0] r, output bit slow);
        int          ea, eb, e;
        bit          s, an, bn, ai, bi;
        longint      m;
        logic [22:0] frac;
        ea   = int'(a[30:23]);
        eb   = int'(b[30:23]);
        s    = a[31] ^ b[31];
        an   = (ea == 255) && (a[22:0] != 0);
        bn   = (eb == 255) && (b[22:0] != 0);
        ai   = (ea == 255) && (a[22:0] == 0);
        bi   = (eb == 255) && (b[22:0] == 0);
        slow = 1'b0;
        e    = ea + eb - 127;
        if (an || bn)                              r = QNAN;
        else if ((ai && eb == 0) || (bi && ea == 0)) r = QNAN;
        else if (ai || bi)                         r = {s, 8'hFF, 23'd0};
        else if (ea == 0 || eb == 0)               r = {s, 31'd0};
        else if (e >= 255)                         r = {s, 8'hFF, 23'd0};
        else if (e <= 0)                           r = {s, 31'd0};
        else begin
            slow = 1'b1;
            m = longint'({1'b1, a[22:0]}) * longint'({1'b1, b[22:0]});
            if (m >= (64'sd1 <<< 47)) begin
                e    = e + 1;
                frac = 23'((m >>> 24) & 64'h7F_FFFF);
            end else begin
                if (fc) e = e + 1;
                frac = 23'((m >>> 23) & 64'h7F_FFFF);
            end
            if (e >= 255) r = {s, 8'hFF, 23'd0};
            else          r = {s, 8'(e), frac};
        end
    endfunction

    // Core stub, acting on the falling edge.
    always @(negedge i_clk) begin
        if (o_mul_valid) begin
            stub_c   = 0;
            stub_res = core_model(o_mul_a, o_mul_b, core_fc);
        end else if (stub_c >= 0) begin
            stub_c++;
        end
        if (stub_c >= 0) begin
            if (stub_c == ((core_mode == 1) ? 3 : 0)) i_mul_valid = 1'b0;
            if (core_mode != 2 && stub_c == ((core_mode == 1) ? 3 : 0) + core_lat) begin
                i_mul_valid  = 1'b1;
                i_mul_result = stub_res;
                stub_c       = -1;
            end
        end
    end

    always @(negedge i_clk) begin
        if (o_mul_valid) pulse_cnt++;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (time %0t, limit 400000)", $time);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    // Issue one request, wait for the result, hold it `hold` cycles, then take it.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] tag,
                         input int hold, output int cyc);
        logic [31:0] exp_r;
        bit          slow;
        logic        exp_e;
        int          p0, n;
        ref_model(a, b, core_fc, exp_r, slow);
        exp_e = 1'b0;
        if (core_mode == 2 && slow) begin
            exp_r = QNAN;
            exp_e = 1'b1;
        end
        n = 0;
        while (!o_ready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        check("req_ready", 32'(o_ready), 32'd1);
        p0      = pulse_cnt;
        i_valid = 1'b1;
        i_a     = a;
        i_b     = b;
        i_tag   = tag;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
        i_tag   = TAG_W'($urandom);
        cyc = 1;
        while (!o_valid && cyc < 64) begin
            @(negedge i_clk);
            cyc++;
        end
        check("resp_valid", 32'(o_valid), 32'd1);
        check("result", o_result, exp_r);
        check("tag", 32'(o_tag), 32'(tag));
        check("err", 32'(o_err), 32'(exp_e));
        check("start_pulses", 32'(pulse_cnt - p0), slow ? 32'd1 : 32'd0);
        if (!slow) check("fast_latency", 32'(cyc), 32'd1);
        for (int k = 0; k < hold; k++) begin
            @(negedge i_clk);
            check("hold_result", o_result, exp_r);
            check("hold_err", 32'(o_err), 32'(exp_e));
            check("hold_ready", 32'(o_ready), 32'd0);
        end
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        check("b2b_ready", 32'(o_ready), 32'd1);
        check("taken_valid", 32'(o_valid), 32'd0);
    endtask

    initial begin
        int          cyc;
        logic [31:0] ra, rb;
        int          cls;
        i_rst_n      = 1'b0;
        i_valid      = 1'b0;
        i_ready      = 1'b0;
        i_a          = 32'd0;
        i_b          = 32'd0;
        i_tag        = '0;
        i_mul_valid  = 1'b0;
        i_mul_result = 32'd0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;

        // Reset state
        check("rst_ready", 32'(o_ready), 32'd1);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_result", o_result, 32'd0);
        check("rst_tag", 32'(o_tag), 32'd0);
        check("rst_err", 32'(o_err), 32'd0);
        check("rst_mul_valid", 32'(o_mul_valid), 32'd0);
        check("rst_mul_a", o_mul_a, 32'd0);

        // 2.0 x 3.0 through the core, latency 3 -> total 5
        core_mode = 0; core_lat = 3; core_fc = 1'b0;
        do_op(32'h4000_0000, 32'h4040_0000, 5'd7, 0, cyc);
        check("mul_lat", 32'(cyc), 32'd5);
        check("mul_a_kept", o_mul_a, 32'h4000_0000);
        check("mul_b_kept", o_mul_b, 32'h4040_0000);

        // Fast-path specials and exponent range
        do_op(32'h7F80_0000, 32'h0000_0000, 5'd1, 0, cyc);
        do_op(32'hFF80_0000, 32'h4000_0000, 5'd2, 0, cyc);
        do_op(32'h7FC0_0001, 32'h3F80_0000, 5'd3, 1, cyc);
        do_op(32'h7F00_0000, 32'h7F00_0000, 5'd4, 0, cyc);
        do_op(32'h2000_0000, 32'h1F00_0000, 5'd5, 0, cyc);
        do_op(32'h8040_0000, 32'h3F80_0000, 5'd6, 0, cyc);
        core_fc = 1'b1;
        do_op(32'h7F3F_FFFF, 32'h4000_0000, 5'd8, 0, cyc);

        // Core carry pushes the exponent to 255 -> infinity via the slow path
        core_fc = 1'b0; core_lat = 2;
        do_op(32'h7F7F_FFFF, 32'h3FC0_0000, 5'd9, 0, cyc);
        // Carry reported by the core drives the re-biased exponent
        core_fc = 1'b1;
        do_op(32'h3F80_0000, 32'h3F80_0000, 5'd10, 0, cyc);
        core_fc = 1'b0;

        // Stale high level for 3 cycles after start is not completion
        core_mode = 1; core_lat = 2;
        check("stale_pre", 32'(i_mul_valid), 32'd1);
        do_op(32'h4040_0000, 32'h4040_0000, 5'd11, 0, cyc);
        check("stale_lat", 32'(cyc), 32'd7);

        // Core never completes -> abort after 31 WAIT cycles, held 5 cycles
        core_mode = 2;
        do_op(32'h3F80_0000, 32'h4000_0000, 5'd12, 5, cyc);
        check("timeout_lat", 32'(cyc), 32'd32);

        // Reset mid-WAIT drops the operation
        core_mode = 0; core_lat = 6;
        i_valid = 1'b1; i_a = 32'h4000_0000; i_b = 32'h4040_0000; i_tag = 5'd13;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        check("midrst_ready", 32'(o_ready), 32'd1);
        check("midrst_valid", 32'(o_valid), 32'd0);
        check("midrst_result", o_result, 32'd0);
        cyc = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge i_clk);
            if (o_valid) cyc++;
        end
        check("midrst_no_valid", 32'(cyc), 32'd0);
        core_lat = 2;
        do_op(32'h3F80_0000, 32'h3F80_0000, 5'd14, 0, cyc);
        check("post_rst_lat", 32'(cyc), 32'd4);

        // Randomized operands, mostly in the slow-path exponent window
        for (int t = 0; t < 40; t++) begin
            cls = int'($urandom_range(0, 9));
            ra  = $urandom;
            rb  = $urandom;
            if (cls == 0)      ra[30:23] = 8'h00;
            else if (cls == 1) begin
                ra[30:23] = 8'hFF;
                if ($urandom_range(0, 1) == 0) ra[22:0] = 23'd0;
            end else           ra[30:23] = 8'($urandom_range(60, 190));
            if ($urandom_range(0, 9) == 0) rb[30:23] = 8'h00;
            else                           rb[30:23] = 8'($urandom_range(60, 190));
            core_lat = int'($urandom_range(1, 4));
            do_op(ra, rb, TAG_W'($urandom), int'($urandom_range(0, 2)), cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
